// File: rtl/muldiv_sequencer_pkg.sv
// RV32M op encodings (funct3), shared between decode and the multiply/divide sequencer.
package muldiv_sequencer_pkg;

  localparam int MD_XLEN = 32;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

endpackage

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M unit: shift-add multiply and restoring divide on one 2*XLEN accumulator,
// with sign fix around an unsigned core and single-cycle handling of the divide corner cases.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_value,
  input  logic [XLEN-1:0] rs2_value,
  input  logic [4:0]      in_RegDest,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      out_RegDest
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [4:0]          rd_q, rd_d;
  logic                done_q, done_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [4:0]          out_rd_q, out_rd_d;

  logic                signed_a, signed_b, a_neg, b_neg, accept;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [XLEN:0]       mul_sum, div_trial;
  logic [2*XLEN-1:0]   mul_next, div_next, step, prod;
  logic [XLEN-1:0]     quo, rem, fin_res;

  // Operand magnitudes and sign-fix polarity for the op being presented.
  always_comb begin
    signed_a = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    signed_b = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    a_neg    = signed_a & rs1_value[XLEN-1];
    b_neg    = signed_b & rs2_value[XLEN-1];
    a_mag    = a_neg ? (~rs1_value + 1'b1) : rs1_value;
    b_mag    = b_neg ? (~rs2_value + 1'b1) : rs2_value;
  end

  // One iteration: multiply keeps {hi, multiplier} and shifts right;
  // divide keeps {remainder, dividend} and shifts left, quotient bits fill from the bottom.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
    div_next  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    step      = op_q[2] ? div_next : mul_next;
    prod      = neg_q ? (~step + 1'b1) : step;
    quo       = neg_q ? (~step[XLEN-1:0] + 1'b1) : step[XLEN-1:0];
    rem       = neg_q ? (~step[2*XLEN-1:XLEN] + 1'b1) : step[2*XLEN-1:XLEN];
    case (op_q)
      MD_MUL:                     fin_res = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fin_res = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:            fin_res = quo;
      default:                    fin_res = rem;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rd_d     = rd_q;
    done_d   = 1'b0;
    result_d = result_q;
    out_rd_d = out_rd_q;
    accept   = (state_q == IDLE) & start & ~flush;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = op;
          rd_d  = in_RegDest;
          cnt_d = '0;
          // Remainder follows the dividend; everything else follows the sign product.
          neg_d = (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);
          acc_d = op[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
          b_d   = op[2] ? b_mag : a_mag;
          if (op[2] && rs2_value == '0) begin
            state_d  = FIN;
            done_d   = 1'b1;
            result_d = op[1] ? rs1_value : '1;
            out_rd_d = in_RegDest;
          end else if (op[2] && !op[0] && rs1_value == INT_MIN && rs2_value == '1) begin
            state_d  = FIN;
            done_d   = 1'b1;
            result_d = op[1] ? '0 : INT_MIN;
            out_rd_d = in_RegDest;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        acc_d = step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) begin
          state_d  = FIN;
          done_d   = 1'b1;
          result_d = fin_res;
          out_rd_d = rd_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d  = IDLE;
      done_d   = 1'b0;
      result_d = result_q;
      out_rd_d = out_rd_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rd_q     <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      out_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rd_q     <= rd_d;
      done_q   <= done_d;
      result_q <= result_d;
      out_rd_q <= out_rd_d;
    end
  end

  assign stall_req   = ~flush & (((state_q == IDLE) & start) | (state_q == RUN));
  assign done        = done_q;
  assign result      = result_q;
  assign out_RegDest = out_rd_q;

endmodule
